// File: rtl/program_counter.sv
// Program counter and fetch sequencer: fetches over a read/ack handshake, holds INSTR until PC_ADVANCE.
// Latency: one FETCH cycle per instruction plus memory wait states, and one EXEC cycle per instruction.

module program_counter #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
  parameter int               INC          = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             PC_OFFSETX,
  input  logic             PC_BASEX,
  input  logic [WIDTH-1:0] PC_ARG,
  input  logic             PC_ADVANCE,
  input  logic             PC_LINKX,
  input  logic             HALT,
  input  logic [WIDTH-1:0] MEM_DATA,
  input  logic             MEM_ACK,
  output logic [WIDTH-1:0] MEM_ADDR,
  output logic             MEM_RD,
  output logic [WIDTH-1:0] INSTR,
  output logic             INSTR_VALID,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_LINK,
  output logic             HALTED
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HLT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] link_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_seq;

  // BASEX without OFFSETX degenerates to an absolute jump to INC; harmless.
  assign pc_seq  = pc_q + INC_W;
  assign pc_next = (PC_BASEX ? {WIDTH{1'b0}} : pc_q) + (PC_OFFSETX ? PC_ARG : INC_W);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (MEM_ACK) state_next = EXEC;
      EXEC:    if (PC_ADVANCE) state_next = HALT ? HLT : FETCH;
      HLT:     if (!HALT) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q    <= RESET_VECTOR;
      link_q  <= {WIDTH{1'b0}};
      instr_q <= {WIDTH{1'b0}};
    end else begin
      if (state == FETCH && MEM_ACK) begin
        instr_q <= MEM_DATA;
      end
      if (state == EXEC && PC_ADVANCE) begin
        pc_q <= pc_next;
        if (PC_LINKX) begin
          link_q <= pc_seq;
        end
      end
    end
  end

  // Status outputs decode straight from the state register so reset clears them asynchronously.
  assign MEM_RD      = (state == FETCH);
  assign INSTR_VALID = (state == EXEC);
  assign HALTED      = (state == HLT);
  assign MEM_ADDR    = pc_q;
  assign PC          = pc_q;
  assign PC_LINK     = link_q;
  assign INSTR       = instr_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboarded bench for program_counter: expected fetches are queued by the stimulus, popped by the monitor.

module tb_program_counter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        PC_OFFSETX;
  logic        PC_BASEX;
  logic [15:0] PC_ARG;
  logic        PC_ADVANCE;
  logic        PC_LINKX;
  logic        HALT;
  logic [15:0] MEM_DATA;
  logic        MEM_ACK;
  logic [15:0] MEM_ADDR;
  logic        MEM_RD;
  logic [15:0] INSTR;
  logic        INSTR_VALID;
  logic [15:0] PC;
  logic [15:0] PC_LINK;
  logic        HALTED;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } fetch_t;

  fetch_t      exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        pending = 1'b0;
  logic [15:0] pend_data = 16'h0;

  program_counter #(
    .WIDTH(16),
    .RESET_VECTOR(16'h0100),
    .INC(2)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .PC_OFFSETX(PC_OFFSETX),
    .PC_BASEX(PC_BASEX),
    .PC_ARG(PC_ARG),
    .PC_ADVANCE(PC_ADVANCE),
    .PC_LINKX(PC_LINKX),
    .HALT(HALT),
    .MEM_DATA(MEM_DATA),
    .MEM_ACK(MEM_ACK),
    .MEM_ADDR(MEM_ADDR),
    .MEM_RD(MEM_RD),
    .INSTR(INSTR),
    .INSTR_VALID(INSTR_VALID),
    .PC(PC),
    .PC_LINK(PC_LINK),
    .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: a fetch handshake pops one expectation; the following cycle must present its instruction.
  always @(negedge CLK) begin
    if (pending) begin
      check("mon_instr_valid", {31'b0, INSTR_VALID}, 32'd1);
      check("mon_instr", {16'b0, INSTR}, {16'b0, pend_data});
      pending = 1'b0;
    end
    if (RESET_N === 1'b1 && MEM_RD === 1'b1 && MEM_ACK === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected_fetch: addr %h with empty queue", MEM_ADDR);
      end else begin
        fetch_t e;
        e = exp_q.pop_front();
        check("mon_fetch_addr", {16'b0, MEM_ADDR}, {16'b0, e.addr});
        pend_data = e.data;
        pending   = 1'b1;
      end
    end
  end

  // Called just after the edge that entered FETCH; returns just after the edge that enters EXEC.
  task automatic fetch(input logic [15:0] addr, input logic [15:0] data, input int waits);
    exp_q.push_back('{addr, data});
    for (int i = 0; i < waits; i++) begin
      MEM_DATA = 16'hDEAD ^ i[15:0];
      check("wait_rd", {31'b0, MEM_RD}, 32'd1);
      check("wait_addr", {16'b0, MEM_ADDR}, {16'b0, addr});
      tick();
    end
    MEM_ACK  = 1'b1;
    MEM_DATA = data;
    tick();
    MEM_ACK  = 1'b0;
    MEM_DATA = 16'hDEAD;
    check("exec_valid", {31'b0, INSTR_VALID}, 32'd1);
  endtask

  task automatic advance(input logic off, input logic base, input logic [15:0] arg,
                         input logic link, input logic halt);
    PC_OFFSETX = off;
    PC_BASEX   = base;
    PC_ARG     = arg;
    PC_LINKX   = link;
    HALT       = halt;
    PC_ADVANCE = 1'b1;
    tick();
    PC_ADVANCE = 1'b0;
    PC_OFFSETX = 1'b0;
    PC_BASEX   = 1'b0;
    PC_ARG     = 16'h0;
    PC_LINKX   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd"}, {31'b0, MEM_RD}, 32'd0);
    check({tag, "_instr_valid"}, {31'b0, INSTR_VALID}, 32'd0);
    check({tag, "_halted"}, {31'b0, HALTED}, 32'd0);
    check({tag, "_pc"}, {16'b0, PC}, 32'h0100);
    check({tag, "_mem_addr"}, {16'b0, MEM_ADDR}, 32'h0100);
    check({tag, "_pc_link"}, {16'b0, PC_LINK}, 32'h0);
    check({tag, "_instr"}, {16'b0, INSTR}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    RESET_N    = 1'b0;
    PC_OFFSETX = 1'b0;
    PC_BASEX   = 1'b0;
    PC_ARG     = 16'h0;
    PC_ADVANCE = 1'b0;
    PC_LINKX   = 1'b0;
    HALT       = 1'b0;
    MEM_DATA   = 16'h1111;
    MEM_ACK    = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");

    // Startup with ACK tied high.
    exp_q.push_back('{16'h0100, 16'h1111});
    RESET_N = 1'b1;
    #2;
    check("start_rd_low", {31'b0, MEM_RD}, 32'd0);
    tick();
    check("start_rd_high", {31'b0, MEM_RD}, 32'd1);
    check("start_addr", {16'b0, MEM_ADDR}, 32'h0100);
    tick();
    MEM_ACK  = 1'b0;
    MEM_DATA = 16'hDEAD;
    check("start_valid", {31'b0, INSTR_VALID}, 32'd1);

    // Sequential flow, 2 cycles per instruction.
    c0 = cyc;
    advance(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("seq1_pc", {16'b0, PC}, 32'h0102);
    check("seq1_rd", {31'b0, MEM_RD}, 32'd1);
    fetch(16'h0102, 16'h2222, 0);
    advance(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("seq2_pc", {16'b0, PC}, 32'h0104);
    fetch(16'h0104, 16'h3333, 0);
    advance(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("seq3_pc", {16'b0, PC}, 32'h0106);
    fetch(16'h0106, 16'h4444, 0);
    check("seq_cycles", cyc - c0, 32'd6);

    // Relative jumps, including backward and wrapping.
    advance(1'b1, 1'b1, 16'h0200, 1'b0, 1'b0);
    fetch(16'h0200, 16'h5555, 0);
    advance(1'b1, 1'b0, 16'hFFF0, 1'b0, 1'b0);
    check("rel_back_pc", {16'b0, PC}, 32'h01F0);
    fetch(16'h01F0, 16'h6666, 0);
    advance(1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    fetch(16'hFFFE, 16'h7777, 0);
    advance(1'b1, 1'b0, 16'h0004, 1'b0, 1'b0);
    check("rel_wrap_pc", {16'b0, PC}, 32'h0002);
    check("nolink_pc_link", {16'b0, PC_LINK}, 32'h0);
    fetch(16'h0002, 16'h8888, 0);

    // Absolute call with link capture.
    advance(1'b1, 1'b1, 16'h0300, 1'b0, 1'b0);
    fetch(16'h0300, 16'h9999, 0);
    advance(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
    check("call_pc", {16'b0, PC}, 32'h1234);
    check("call_link", {16'b0, PC_LINK}, 32'h0302);
    fetch(16'h1234, 16'hAAAA, 0);

    // BASEX without OFFSETX: next is INC; link keeps its value.
    advance(1'b0, 1'b1, 16'h5678, 1'b0, 1'b0);
    check("basex_only_pc", {16'b0, PC}, 32'h0002);
    check("link_held", {16'b0, PC_LINK}, 32'h0302);

    // Wait states with HALT and stray advance controls asserted during FETCH.
    HALT       = 1'b1;
    PC_ADVANCE = 1'b1;
    PC_OFFSETX = 1'b1;
    PC_BASEX   = 1'b1;
    PC_ARG     = 16'hFFFF;
    PC_LINKX   = 1'b1;
    fetch(16'h0002, 16'hBBBB, 3);
    PC_ADVANCE = 1'b0;
    PC_OFFSETX = 1'b0;
    PC_BASEX   = 1'b0;
    PC_ARG     = 16'h0;
    PC_LINKX   = 1'b0;
    check("fetch_ignores_adv_pc", {16'b0, PC}, 32'h0002);
    check("fetch_ignores_adv_link", {16'b0, PC_LINK}, 32'h0302);

    // Halt at advance; ACK ignored while halted.
    advance(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    check("halt_halted", {31'b0, HALTED}, 32'd1);
    check("halt_rd", {31'b0, MEM_RD}, 32'd0);
    check("halt_pc", {16'b0, PC}, 32'h0004);
    MEM_ACK  = 1'b1;
    MEM_DATA = 16'hBEEF;
    repeat (2) tick();
    check("halt_hold_pc", {16'b0, PC}, 32'h0004);
    check("halt_hold", {31'b0, HALTED}, 32'd1);
    check("halt_instr_kept", {16'b0, INSTR}, 32'hBBBB);
    MEM_ACK  = 1'b0;
    MEM_DATA = 16'hDEAD;
    HALT     = 1'b0;
    tick();
    check("unhalt_rd", {31'b0, MEM_RD}, 32'd1);
    check("unhalt_addr", {16'b0, MEM_ADDR}, 32'h0004);
    check("unhalt_halted", {31'b0, HALTED}, 32'd0);
    fetch(16'h0004, 16'hCCCC, 1);

    // Reset in the middle of a fetch.
    advance(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("pre_rst_rd", {31'b0, MEM_RD}, 32'd1);
    check("pre_rst_link", {16'b0, PC_LINK}, 32'h0006);
    #2;
    RESET_N = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    RESET_N = 1'b1;
    #1;
    check("restart_rd_low", {31'b0, MEM_RD}, 32'd0);
    tick();
    check("restart_rd_high", {31'b0, MEM_RD}, 32'd1);
    check("restart_addr", {16'b0, MEM_ADDR}, 32'h0100);
    fetch(16'h0100, 16'hDDDD, 0);
    advance(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("restart_seq_pc", {16'b0, PC}, 32'h0102);

    repeat (2) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
